reg_file_param: RTL and testbench

//   Parametrised 2-read/1-write register file for the datapath; next generation of the 32x32 file.

---
 rtl/reg_file_param.sv | 138 +++++++++++++
 tb/tb_reg_file_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with registered reads, optional
// write-to-read bypass, optional hardwired zero register and a clear sequencer
// that zeroes every entry after reset or on request.
module reg_file_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic [ADDR_W-1:0] rW,
  input  logic [WIDTH-1:0]  busW,
  input  logic              regWr,
  input  logic              clr,
  output logic [WIDTH-1:0]  busA,
  output logic [WIDTH-1:0]  busB,
  output logic              ready
);

  // One extra bit so DEPTH == 2**ADDR_W can still be compared without wrapping.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   clr_cnt;
  logic [CNT_W-1:0]   clr_cnt_n;
  logic               ready_n;
  logic [WIDTH-1:0]   bus_a_n;
  logic [WIDTH-1:0]   bus_b_n;
  logic               wr_en_c;
  logic [WIDTH-1:0]   mem [DEPTH];

  // Addresses at or above DEPTH never alias onto real entries.
  function automatic logic in_range(input logic [ADDR_W-1:0] r);
    return 32'(r) < DEPTH;
  endfunction

  // True when r names the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  // Read value seen by a port this edge: zero, forwarded write data, or stored contents.
  function automatic logic [WIDTH-1:0] read_val(input logic [ADDR_W-1:0] r);
    logic [WIDTH-1:0] v;
    v = '0;
    if (!in_range(r) || is_zero_reg(r)) begin
      v = '0;
    end else if ((BYPASS != 0) && wr_en_c && (rW == r)) begin
      v = busW;
    end else begin
      v = mem[r];
    end
    return v;
  endfunction

  // User write qualifies only in READY without a clear request on this edge.
  assign wr_en_c = (state == READY) && !clr && regWr && in_range(rW) && !is_zero_reg(rW);

  // Storage: the sequencer zeroes one entry per edge, otherwise a qualified user write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (wr_en_c) begin
        mem[rW] <= busW;
      end
    end
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    ready_n   = ready;
    bus_a_n   = busA;
    bus_b_n   = busB;
    case (state)
      CLEAR: begin
        bus_a_n   = '0;
        bus_b_n   = '0;
        ready_n   = 1'b0;
        clr_cnt_n = clr_cnt + CNT_W'(1);
        if (clr_cnt == CNT_W'(DEPTH - 1)) begin
          state_n = READY;
          ready_n = 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_n   = CLEAR;
          clr_cnt_n = '0;
          ready_n   = 1'b0;
          bus_a_n   = '0;
          bus_b_n   = '0;
        end else begin
          ready_n = 1'b1;
          bus_a_n = read_val(rA);
          bus_b_n = read_val(rB);
        end
      end
      default: begin
        state_n   = CLEAR;
        clr_cnt_n = '0;
        ready_n   = 1'b0;
        bus_a_n   = '0;
        bus_b_n   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset into the clear sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      busA    <= '0;
      busB    <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      ready   <= ready_n;
      busA    <= bus_a_n;
      busB    <= bus_b_n;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised and directed bench for reg_file_param. Two instances share one
// stimulus stream: the default configuration and a DEPTH=20, no-bypass,
// ordinary-register-0 configuration. Each is checked against its own model.
module tb_reg_file_param;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra, rb, rw;
  logic [W-1:0]  busw;
  logic          regwr, clr;
  logic [W-1:0]  busa0, busb0, busa1, busb1;
  logic          ready0, ready1;

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .rA(ra), .rB(rb), .rW(rw), .busW(busw), .regWr(regwr),
    .clr(clr), .busA(busa0), .busB(busb0), .ready(ready0)
  );

  reg_file_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .rA(ra), .rB(rb), .rW(rw), .busW(busw), .regWr(regwr),
    .clr(clr), .busA(busa1), .busB(busb1), .ready(ready1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, the register contents, the number of clear
  // cycles still outstanding, and the expected registered outputs.
  int          dep [2] = '{32, 20};
  bit          zr  [2] = '{1'b1, 1'b0};
  bit          byp [2] = '{1'b1, 1'b0};
  logic [31:0] mm  [2][32];
  int          left[2];
  logic [31:0] ea  [2];
  logic [31:0] eb  [2];
  logic        er  [2];

  function automatic logic [31:0] mread(int k, int r, bit wr);
    if (r >= dep[k] || (zr[k] && r == 0)) return 32'h0;
    if (byp[k] && wr && int'(rw) == r) return busw;
    return mm[k][r];
  endfunction

  // A clear leaves every entry zero and the file unusable for DEPTH edges.
  task automatic start_clear(int k);
    left[k] = dep[k];
    er[k]   = 1'b0;
    ea[k]   = 32'h0;
    eb[k]   = 32'h0;
    for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) start_clear(k);
  endtask

  task automatic model_edge();
    bit wr;
    for (int k = 0; k < 2; k++) begin
      if (left[k] > 0) begin
        left[k]--;
        ea[k] = 32'h0;
        eb[k] = 32'h0;
        er[k] = (left[k] == 0);
      end else if (clr) begin
        start_clear(k);
      end else begin
        wr = regwr && (int'(rw) < dep[k]) && !(zr[k] && rw == '0);
        ea[k] = mread(k, int'(ra), wr);
        eb[k] = mread(k, int'(rb), wr);
        if (wr) mm[k][rw] = busw;
        er[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a0"}, busa0, ea[0]);
    check({tag, "_b0"}, busb0, eb[0]);
    check({tag, "_r0"}, 32'(ready0), 32'(er[0]));
    check({tag, "_a1"}, busa1, ea[1]);
    check({tag, "_b1"}, busb1, eb[1]);
    check({tag, "_r1"}, 32'(ready1), 32'(er[1]));
  endtask

  // Inputs are already applied; advance one edge and compare just after it.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] w,
                       input logic [W-1:0] d, input logic we, input logic c, input string tag);
    ra = a; rb = b; rw = w; busw = d; regwr = we; clr = c;
    step(tag);
  endtask

  task automatic rand_step(input int clr_odds, input string tag);
    ra    = AW'($urandom_range(0, 31));
    rb    = AW'($urandom_range(0, 31));
    rw    = AW'($urandom_range(0, 31));
    busw  = $urandom;
    regwr = 1'($urandom_range(0, 1));
    clr   = (clr_odds > 0) ? ($urandom_range(1, clr_odds) == 1) : 1'b0;
    step(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    ra = '0; rb = '0; rw = '0; busw = '0; regwr = 1'b0; clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Power-up clear with writes/clear requests that must be ignored.
    for (int i = 0; i < 34; i++) rand_step(3, "pwrup");

    // Every register reads zero after the clear.
    for (int i = 0; i < 32; i++) drive(AW'(i), AW'(31 - i), '0, '0, 1'b0, 1'b0, "zero_sweep");

    // Plain write then read.
    drive('0, '0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, "wr5");
    drive(5'd5, 5'd5, '0, '0, 1'b0, 1'b0, "rd5");
    check("rd5_const", busa0, 32'hDEADBEEF);

    // Same-edge write and read of one address on both ports.
    drive('0, '0, 5'd7, 32'h0000AAAA, 1'b1, 1'b0, "wr7_old");
    drive(5'd7, 5'd7, 5'd7, 32'h00001234, 1'b1, 1'b0, "byp7");
    check("byp_on_a", busa0, 32'h00001234);
    check("byp_on_b", busb0, 32'h00001234);
    check("byp_off_a", busa1, 32'h0000AAAA);
    check("byp_off_b", busb1, 32'h0000AAAA);

    // Register 0: hardwired zero versus ordinary.
    drive('0, '0, '0, 32'hFFFFFFFF, 1'b1, 1'b0, "wr0");
    drive('0, '0, '0, '0, 1'b0, 1'b0, "rd0");
    check("zero_reg_on", busa0, 32'h0);
    check("zero_reg_off", busa1, 32'hFFFFFFFF);

    // Out-of-range write on the DEPTH=20 instance is dropped; read returns zero.
    drive('0, '0, 5'd25, 32'h00000055, 1'b1, 1'b0, "wr25");
    drive(5'd25, 5'd25, '0, '0, 1'b0, 1'b0, "rd25");
    check("oor_read", busa1, 32'h0);
    for (int i = 0; i < 20; i++) drive(AW'(i), AW'(19 - i), '0, '0, 1'b0, 1'b0, "oor_sweep");

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) rand_step(60, "rand");
    for (int i = 0; i < 34; i++) rand_step(0, "settle");

    // Fill with nonzero values, clear once, keep writing during the clear.
    for (int i = 0; i < 32; i++) drive('0, '0, AW'(i), 32'(i) * 32'h01010101 + 32'h11, 1'b1, 1'b0, "fill");
    drive('0, '0, '0, '0, 1'b0, 1'b1, "clr_req");
    for (int i = 0; i < 32; i++) drive('0, '0, AW'(i), $urandom | 32'h1, 1'b1, 1'b0, "clr_busy");
    for (int i = 0; i < 32; i++) drive(AW'(i), AW'(i), '0, '0, 1'b0, 1'b0, "clr_sweep");

    // Reset in the middle of a clear: the sequence restarts from the beginning.
    drive('0, '0, '0, '0, 1'b0, 1'b1, "clr_req2");
    for (int i = 0; i < 10; i++) rand_step(0, "clr_part");
    clr = 1'b0; regwr = 1'b0;
    do_reset();
    for (int i = 0; i < 34; i++) rand_step(4, "restart");
    for (int i = 0; i < 100; i++) rand_step(50, "tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
